// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: byte FIFO behind uart_rx; the core reads single bytes or big-endian 32-bit words.
// Framing-error bytes are dropped and counted, and overflow is sticky until clr_flags.
module uart_rx_buffer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  rx_ferr,
    input  logic                  rd_req,
    input  logic                  rd_word,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic [7:0]            ferr_count,
    input  logic                  clr_flags
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                state_q;
    logic [7:0]            mem_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            ferr_q, ferr_d;
    logic                  word_q;
    logic [2:0]            need_q, idx_q;
    logic [31:0]           asm_q, asm_d, rd_data_q;
    logic                  rd_valid_q;
    logic                  push, pop, full;
    logic [7:0]            pop_byte;

    // count never exceeds the depth, so its MSB alone marks full
    assign full     = count_q[ADDR_WIDTH];
    assign pop      = (state_q == COLLECT) && (count_q != '0);
    assign push     = rx_ready && !rx_ferr && (!full || pop);
    assign pop_byte = mem_q[rd_ptr_q];

    always_comb begin
        count_d    = count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
        overflow_d = clr_flags ? 1'b0 : overflow_q | (rx_ready & ~rx_ferr & full & ~pop);
        ferr_d     = clr_flags ? 8'd0 : (rx_ready && rx_ferr && ferr_q != 8'hFF) ? ferr_q + 8'd1 : ferr_q;
        asm_d      = word_q ? {asm_q[23:0], pop_byte} : {24'd0, pop_byte};
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ferr_q     <= 8'd0;
        end else begin
            wr_ptr_q   <= push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ferr_q     <= ferr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= 1'b0;
            need_q     <= 3'd0;
            idx_q      <= 3'd0;
            asm_q      <= 32'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rd_valid_q <= 1'b0;
                    if (rd_req) begin
                        word_q  <= rd_word;
                        need_q  <= rd_word ? 3'd4 : 3'd1;
                        idx_q   <= 3'd0;
                        asm_q   <= 32'd0;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (pop) begin
                        asm_q <= asm_d;
                        idx_q <= idx_q + 3'd1;
                        if (idx_q + 3'd1 == need_q) begin
                            rd_data_q  <= asm_d;
                            rd_valid_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE: begin
                    rd_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = (state_q != IDLE);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign ferr_count = ferr_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed checks of uart_rx_buffer with a 4-byte FIFO (ADDR_WIDTH=2).
module tb_uart_rx_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;
    logic        rx_ferr = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_word = 1'b0;
    logic        clr_flags = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic [2:0]  count;
    logic        overflow;
    logic [7:0]  ferr_count;
    int checks = 0;
    int failures = 0;
    int nvalid = 0;

    uart_rx_buffer #(.ADDR_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
        .rd_req(rd_req), .rd_word(rd_word), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .count(count), .overflow(overflow), .ferr_count(ferr_count),
        .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (rd_valid) nvalid++;
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b;
        rx_ferr = 1'b0;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic ferr_strobe();
        rx_data = 8'hEE;
        rx_ferr = 1'b1;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_ferr = 1'b0;
    endtask

    task automatic rd(input logic w, input int exp_lat, input logic [31:0] exp, input string tag);
        int lat;
        tick();
        rd_word = w;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        lat = 1;
        while (!rd_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, rd_data, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_data", rd_data, 32'd0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", ferr_count, 0);

        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        chk("word_cnt4", count, 4);
        chk("word_ovf", overflow, 0);
        rd(1'b1, 5, 32'h12345678, "word");
        chk("word_cnt0", count, 0);

        push(8'hAA);
        rd(1'b0, 2, 32'h000000AA, "byte_aa");
        rd_word = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("done_req_busy", busy, 0);
        nvalid = 0;
        run(5);
        chk("done_req_novalid", nvalid, 0);

        rd_word = 1'b1;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        nvalid = 0;
        run(20);
        chk("starve_busy", busy, 1);
        for (int i = 1; i <= 4; i++) begin
            push(8'(i));
            if (i < 4) run(29);
        end
        chk("starve_novalid", nvalid, 0);
        chk("starve_busy2", busy, 1);
        chk("starve_cnt1", count, 1);
        chk("starve_valid0", rd_valid, 0);
        tick();
        chk("starve_valid", rd_valid, 1);
        chk("starve_data", rd_data, 32'h01020304);
        chk("starve_cnt0", count, 0);

        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        chk("ovf_cnt", count, 4);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 4; i++) rd(1'b0, 2, 32'h10 + i, "ovf_rd");
        for (int i = 0; i < 12; i++) begin
            push(8'h20 + 8'(i));
            rd(1'b0, 2, 32'h20 + i, "wrap_rd");
        end
        chk("wrap_cnt", count, 0);

        tick();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        tick();
        rd_word = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        rx_data = 8'hA4;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("full_pp_valid", rd_valid, 1);
        chk("full_pp_data", rd_data, 32'hA0);
        chk("full_pp_cnt", count, 4);
        chk("full_pp_ovf", overflow, 0);
        for (int i = 1; i <= 4; i++) rd(1'b0, 2, 32'hA0 + i, "full_pp_rd");

        ferr_strobe();
        push(8'h55);
        ferr_strobe();
        ferr_strobe();
        chk("ferr_cnt3", ferr_count, 3);
        chk("ferr_stored", count, 1);
        rd(1'b0, 2, 32'h55, "ferr_rd");
        chk("ferr_cnt0", count, 0);
        for (int i = 0; i < 260; i++) ferr_strobe();
        chk("ferr_sat", ferr_count, 255);
        for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
        chk("ovf2", overflow, 1);
        clr_flags = 1'b1;
        ferr_strobe();
        clr_flags = 1'b0;
        chk("clr_ferr", ferr_count, 0);
        chk("clr_ovf2", overflow, 0);

        tick();
        rd_word = 1'b1;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        chk("mid_cnt2", count, 2);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_data", rd_data, 32'd0);
        #3;
        rst = 1'b0;
        nvalid = 0;
        run(10);
        chk("post_rst_novalid", nvalid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_cnt", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
